lsu_multicycle: RTL and testbench

- Parametrised multicycle load/store unit for the RISC-V datapath.
- Replaces the direct single-cycle data-memory hookup with a req/ack handshake, so the unit tolerates memories with variable latency.
- Supports every RISC-V load/store size with byte-lane alignment, sign/zero extension, byte enables and fault reporting.
- The control FSM pulses start and then stalls on busy until done.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_lane_align.sv | 56 +++++
 rtl/lsu_multicycle.sv | 157 +++++++++++++++
 tb/tb_lsu_multicycle.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the multicycle load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_SIZE     = 2'b10,
    FLT_TIMEOUT  = 2'b11
  } lsu_fault_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Access size in bytes; funct3[2] only selects signedness.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and store shift toward memory, load
// shift/truncate/extend back from the aligned memory word.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int XLEN  = 64,
  localparam int NB    = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [OFF_W-1:0] off_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [NB-1:0]    be_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic [XLEN-1:0]  load_o
);

  logic [NB-1:0]   mask;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            sign;

  always_comb begin
    case (funct3_i[1:0])
      2'd0:    mask = NB'(1);
      2'd1:    mask = NB'(3);
      2'd2:    mask = NB'(15);
      default: mask = '1;
    endcase
  end

  assign be_o    = mask << off_i;
  assign wdata_o = wdata_i << {off_i, 3'b000};
  assign shifted = rdata_i >> {off_i, 3'b000};

  // The unshifted byte mask doubles as the bit mask of the kept low bytes.
  always_comb begin
    keep = '0;
    for (int b = 0; b < NB; b++) begin
      keep[8*b +: 8] = {8{mask[b]}};
    end
  end

  always_comb begin
    case (funct3_i[1:0])
      2'd0:    sign = shifted[7];
      2'd1:    sign = shifted[15];
      2'd2:    sign = shifted[31];
      default: sign = shifted[XLEN-1];
    endcase
  end

  assign load_o = (shifted & keep) | ((sign && !funct3_i[2]) ? ~keep : '0);

endmodule

// File: rtl/lsu_multicycle.sv
// Multicycle load/store unit with a req/ack memory handshake.
// Optional LSU_TIMEOUT_EN adds a bounded wait for mem_ack (fault code 11).
module lsu_multicycle
  import lsu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int ADDR_W      = 64,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_store,
  input  logic [2:0]          funct3,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [XLEN-1:0]     wdata,
  output logic                busy,
  output logic                done,
  output logic [XLEN-1:0]     load_data,
  output logic [1:0]          fault,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_t        state_q;
  lsu_fault_t        fault_q;
  logic              busy_q, done_q, mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]   load_data_q;
  logic              op_st_q;
  logic [2:0]        op_f3_q;
  logic [OFF_W-1:0]  op_off_q;
  logic [XLEN-1:0]   op_wdata_q;

  logic              size_bad, misalign;
  logic [NB-1:0]     lane_be;
  logic [XLEN-1:0]   lane_wdata, lane_load;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]  tmo_cnt_q;
`endif

  assign size_bad = (funct3 == 3'b111) || (is_store && funct3[2]) ||
                    ((XLEN == 32) && (funct3[1:0] == 2'b11));
  assign misalign = (addr[OFF_W-1:0] & OFF_W'(size_bytes(funct3) - 4'd1)) != '0;

  lsu_lane_align #(.XLEN(XLEN)) u_lane (
    .off_i    (op_off_q),
    .funct3_i (op_f3_q),
    .wdata_i  (op_wdata_q),
    .rdata_i  (mem_rdata),
    .be_o     (lane_be),
    .wdata_o  (lane_wdata),
    .load_o   (lane_load)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fault_q     <= FLT_NONE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      load_data_q <= '0;
      op_st_q     <= 1'b0;
      op_f3_q     <= '0;
      op_off_q    <= '0;
      op_wdata_q  <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_st_q    <= is_store;
            op_f3_q    <= funct3;
            op_off_q   <= addr[OFF_W-1:0];
            op_wdata_q <= wdata;
            busy_q     <= 1'b1;
            if (size_bad) begin
              state_q <= FAULT;
              done_q  <= 1'b1;
              fault_q <= FLT_SIZE;
            end else if (misalign) begin
              state_q <= FAULT;
              done_q  <= 1'b1;
              fault_q <= FLT_MISALIGN;
            end else begin
              state_q    <= REQ;
              mem_req_q  <= 1'b1;
              mem_we_q   <= is_store;
              mem_addr_q <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`ifdef LSU_TIMEOUT_EN
              tmo_cnt_q  <= '0;
`endif
            end
          end
        end
        REQ: begin
          // An ack on the expiry cycle takes priority over the timeout.
          if (mem_ack) begin
            if (!op_st_q) load_data_q <= lane_load;
            state_q   <= RESP;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            fault_q   <= FLT_NONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_q   <= RESP;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            fault_q   <= FLT_TIMEOUT;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        RESP, FAULT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          fault_q <= FLT_NONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign load_data = load_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  // Lane outputs come from latched operands; quiet outside a request.
  assign mem_be    = mem_req_q ? lane_be    : '0;
  assign mem_wdata = mem_req_q ? lane_wdata : '0;

endmodule

// File: tb/tb_lsu_multicycle.sv
// Self-checking bench for lsu_multicycle (XLEN = 64): directed vector table,
// reset/handshake corner sequences and randomized accesses against a model.
module tb_lsu_multicycle;

  localparam int XLEN        = 64;
  localparam int ADDR_W      = 64;
  localparam int TIMEOUT_CYC = 16;

  logic        clk, rst, start, is_store, busy, done, mem_req, mem_we, mem_ack;
  logic [2:0]  funct3;
  logic [1:0]  fault;
  logic [7:0]  mem_be;
  logic [63:0] addr, wdata, load_data, mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_ld;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_multicycle #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .load_data(load_data),
    .fault(fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [63:0] a, wd, rd;
    int          lat;     // REQ cycle carrying the ack; 0 = never ack
    bit          poke;    // issue a second start while busy
    logic [1:0]  ef;
    logic [63:0] eld;
    logic [7:0]  ebe;
    logic [63:0] ema, emw;
  } vec_t;

  function automatic vec_t mk(bit st, logic [2:0] f3, logic [63:0] a, logic [63:0] wd,
                              logic [63:0] rd, int lat, bit poke, logic [1:0] ef,
                              logic [63:0] eld, logic [7:0] ebe, logic [63:0] ema,
                              logic [63:0] emw);
    vec_t v;
    v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.rd = rd; v.lat = lat; v.poke = poke;
    v.ef = ef; v.eld = eld; v.ebe = ebe; v.ema = ema; v.emw = emw;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model from the architectural rules.
  function automatic logic [1:0] m_fault(bit st, logic [2:0] f3, logic [63:0] a);
    int sz;
    sz = 1 << f3[1:0];
    if (f3 == 3'b111 || (st && f3[2])) return 2'b10;
    if ((a % 64'(sz)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [63:0] m_load(logic [2:0] f3, logic [63:0] a, logic [63:0] rd);
    int sz, off;
    logic [63:0] v, lowm;
    sz  = 1 << f3[1:0];
    off = int'(a[2:0]);
    v   = rd >> (8 * off);
    lowm = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
    v = v & lowm;
    if (!f3[2] && v[8*sz-1]) v = v | ~lowm;
    return v;
  endfunction

  function automatic logic [7:0] m_be(logic [2:0] f3, logic [63:0] a);
    logic [15:0] t;
    t = (16'd1 << (1 << f3[1:0])) - 16'd1;
    t = t << int'(a[2:0]);
    return t[7:0];
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int cyc, reqc, unstable, exp_req, exp_done, done_cyc;
    bit got_done;
    logic [63:0] a0, w0, ld_at;
    logic [7:0]  b0;
    logic        we0, bsy_at;
    logic [1:0]  flt_at;
    if (v.ef == 2'b00 || v.ef == 2'b11) exp_req = (v.lat == 0) ? TIMEOUT_CYC : v.lat;
    else exp_req = 0;
    exp_done = (exp_req == 0) ? 1 : exp_req + 1;
    cyc = 0; reqc = 0; unstable = 0; got_done = 0; done_cyc = 0;
    a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0; ld_at = '0; bsy_at = 1'b0; flt_at = '0;
    @(negedge clk);
    start = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.a; wdata = v.wd;
    mem_ack = 1'b0; mem_rdata = ~v.rd;
    while (!got_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        reqc++;
        if (reqc == 1) begin
          a0 = mem_addr; w0 = mem_wdata; b0 = mem_be; we0 = mem_we;
        end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_be !== b0 || mem_we !== we0) begin
          unstable++;
        end
      end
      if (done) begin
        got_done = 1; done_cyc = cyc; flt_at = fault; bsy_at = busy; ld_at = load_data;
      end
      mem_ack   = !got_done && mem_req && v.lat != 0 && reqc == v.lat;
      mem_rdata = mem_ack ? v.rd : ~v.rd;
      start     = v.poke && reqc == 2 && !got_done;
      addr      = (v.poke && reqc >= 2) ? (v.a ^ 64'h100) : v.a;
    end
    mem_ack = 1'b0; start = 1'b0;
    chk({tag, ".done_seen"}, 64'(got_done), 64'd1);
    chk({tag, ".done_cycle"}, 64'(done_cyc), 64'(exp_done));
    chk({tag, ".fault"}, 64'(flt_at), 64'(v.ef));
    chk({tag, ".busy_at_done"}, 64'(bsy_at), 64'(v.ef == 2'b01 || v.ef == 2'b10));
    chk({tag, ".load_data"}, ld_at, v.eld);
    chk({tag, ".req_cycles"}, 64'(reqc), 64'(exp_req));
    chk({tag, ".req_stable"}, 64'(unstable), 64'd0);
    if (exp_req > 0) begin
      chk({tag, ".mem_we"}, 64'(we0), 64'(v.st));
      chk({tag, ".mem_addr"}, a0, v.ema);
      chk({tag, ".mem_be"}, 64'(b0), 64'(v.ebe));
      chk({tag, ".mem_wdata"}, w0, v.emw);
    end
    @(negedge clk);
    chk({tag, ".done_after"}, 64'(done), 64'd0);
    chk({tag, ".busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[15];
    vec_t v;
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.mem_req", 64'(mem_req), 64'd0);
    chk("reset.mem_we", 64'(mem_we), 64'd0);
    chk("reset.mem_be", 64'(mem_be), 64'd0);
    chk("reset.load_data", load_data, 64'd0);
    chk("reset.mem_addr", mem_addr, 64'd0);
    chk("reset.mem_wdata", mem_wdata, 64'd0);
    chk("reset.fault", 64'(fault), 64'd0);
    rst = 1'b1;

    tv[0]  = mk(0, 3'b000, 64'h1003, 64'h0, 64'h0011223384556677, 1, 0, 2'b00,
                64'hFFFFFFFFFFFFFF84, 8'h08, 64'h1000, 64'h0);
    tv[1]  = mk(0, 3'b100, 64'h1003, 64'h0, 64'h0011223384556677, 1, 0, 2'b00,
                64'h84, 8'h08, 64'h1000, 64'h0);
    tv[2]  = mk(1, 3'b001, 64'h2006, 64'hABCD, 64'hDEADBEEFDEADBEEF, 2, 0, 2'b00,
                64'h84, 8'hC0, 64'h2000, 64'hABCD000000000000);
    tv[3]  = mk(0, 3'b010, 64'h3002, 64'h0, 64'h1, 1, 0, 2'b01, 64'h84, 8'h0, 64'h0, 64'h0);
    tv[4]  = mk(1, 3'b100, 64'h10, 64'h0, 64'h1, 1, 0, 2'b10, 64'h84, 8'h0, 64'h0, 64'h0);
    tv[5]  = mk(0, 3'b011, 64'h4000, 64'h0, 64'h0123456789ABCDEF, 5, 1, 2'b00,
                64'h0123456789ABCDEF, 8'hFF, 64'h4000, 64'h0);
    tv[6]  = mk(0, 3'b111, 64'h0, 64'h0, 64'h1, 1, 0, 2'b10, 64'h0123456789ABCDEF,
                8'h0, 64'h0, 64'h0);
    tv[7]  = mk(0, 3'b001, 64'h5006, 64'h0, 64'h8765000000000000, 3, 0, 2'b00,
                64'hFFFFFFFFFFFF8765, 8'hC0, 64'h5000, 64'h0);
    tv[8]  = mk(0, 3'b101, 64'h5006, 64'h0, 64'h8765000000000000, 1, 0, 2'b00,
                64'h8765, 8'hC0, 64'h5000, 64'h0);
    tv[9]  = mk(0, 3'b010, 64'h6004, 64'h0, 64'h8000000100000000, 1, 0, 2'b00,
                64'hFFFFFFFF80000001, 8'hF0, 64'h6000, 64'h0);
    tv[10] = mk(0, 3'b110, 64'h6004, 64'h0, 64'h8000000100000000, 1, 0, 2'b00,
                64'h80000001, 8'hF0, 64'h6000, 64'h0);
    tv[11] = mk(1, 3'b011, 64'h7008, 64'h1122334455667788, 64'hFFFFFFFFFFFFFFFF, 2, 0,
                2'b00, 64'h80000001, 8'hFF, 64'h7008, 64'h1122334455667788);
    tv[12] = mk(1, 3'b010, 64'h7006, 64'h5, 64'h0, 1, 0, 2'b01, 64'h80000001,
                8'h0, 64'h0, 64'h0);
    tv[13] = mk(1, 3'b000, 64'h7007, 64'h5A, 64'h0, 1, 0, 2'b00, 64'h80000001,
                8'h80, 64'h7000, 64'h5A00000000000000);
    tv[14] = mk(0, 3'b001, 64'h10, 64'h0, 64'hFFFFFFFFFFFF7FFF, 1, 0, 2'b00,
                64'h7FFF, 8'h03, 64'h10, 64'h0);
    for (int i = 0; i < 15; i++) run_op(tv[i], $sformatf("vec%0d", i));
    exp_ld = 64'h7FFF;

    // Stray acks while idle must not start or finish anything.
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle_ack%0d.done", i), 64'(done), 64'd0);
      chk($sformatf("idle_ack%0d.mem_req", i), 64'(mem_req), 64'd0);
    end
    mem_ack = 1'b0;
    chk("idle_ack.load_data", load_data, exp_ld);

    // Asynchronous reset while a request is outstanding.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 64'h8000;
    @(negedge clk);
    start = 1'b0;
    chk("rst_mid.req_before", 64'(mem_req), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid.mem_req", 64'(mem_req), 64'd0);
    chk("rst_mid.busy", 64'(busy), 64'd0);
    chk("rst_mid.done", 64'(done), 64'd0);
    chk("rst_mid.load_data", load_data, 64'd0);
    exp_ld = 64'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.idle_busy", 64'(busy), 64'd0);
    chk("rst_mid.idle_done", 64'(done), 64'd0);
    exp_ld = m_load(3'b010, 64'h8000, 64'h123456789ABCDEF0);
    v = mk(0, 3'b010, 64'h8000, 64'h0, 64'h123456789ABCDEF0, 2, 0, 2'b00, exp_ld,
           8'h0F, 64'h8000, 64'h0);
    run_op(v, "rst_mid.lw");

    for (int i = 0; i < 80; i++) begin
      bit          st;
      logic [2:0]  f3;
      logic [63:0] a, wd, rd;
      logic [1:0]  ef;
      int          sz;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      sz = 1 << f3[1:0];
      if ($urandom_range(0, 3) != 0) a = a & ~64'(sz - 1);
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      ef = m_fault(st, f3, a);
      if (ef == 2'b00 && !st) exp_ld = m_load(f3, a, rd);
      v = mk(st, f3, a, wd, rd, $urandom_range(1, 4), 0, ef, exp_ld, m_be(f3, a),
             a & ~64'h7, wd << (8 * int'(a[2:0])));
      run_op(v, $sformatf("rnd%0d", i));
    end

`ifdef LSU_TIMEOUT_EN
    v = mk(0, 3'b010, 64'h9000, 64'h0, 64'h55, 0, 0, 2'b11, exp_ld, 8'h0F, 64'h9000, 64'h0);
    run_op(v, "timeout.noack");
    exp_ld = 64'h55;
    v = mk(0, 3'b010, 64'h9000, 64'h0, 64'h55, TIMEOUT_CYC, 0, 2'b00, exp_ld, 8'h0F,
           64'h9000, 64'h0);
    run_op(v, "timeout.ack_last");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
